// File: rtl/snake_pkg.sv
// Shared constants, state encoding and helpers for the snake sequencer.
// Grid bounds, mode codes, body length limits and tick divisor math.
package snake_pkg;

    localparam logic [5:0] X_MIN = 6'd1;
    localparam logic [5:0] X_MAX = 6'd38;
    localparam logic [5:0] Y_MIN = 6'd1;
    localparam logic [5:0] Y_MAX = 6'd28;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_PLAY = 2'd1;
    localparam logic [1:0] MODE_OVER = 2'd2;

    localparam int MAX_NODES = 16;
    localparam int INIT_LEN  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_SCAN,
        S_RUN,
        S_OVER
    } state_t;

    // True when (x, y) lies inside the playable field.
    function automatic logic in_field(input logic [5:0] x,
                                      input logic [5:0] y);
        return (x >= X_MIN) && (x <= X_MAX) &&
               (y >= Y_MIN) && (y <= Y_MAX);
    endfunction

    // Index of the last body node: length is 3+score, capped at 16.
    function automatic logic [4:0] last_node(input logic [3:0] score);
        logic [4:0] len;
        len = 5'(INIT_LEN) + {1'b0, score};
        if (len > 5'(MAX_NODES)) len = 5'(MAX_NODES);
        return len - 5'd1;
    endfunction

    // Tick period shrinks with score, never below a quarter of base.
    function automatic int tick_div(input int base,
                                    input int step,
                                    input logic [3:0] score);
        int d;
        d = base - int'(score) * step;
        if (d < base / 4) d = base / 4;
        return d;
    endfunction

endpackage

// File: rtl/snake_lfsr16.sv
// 16-bit Galois LFSR, taps 16,14,13,11, free-running every cycle.
// Supplies the random apple candidates; the seed must be nonzero.
module snake_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    // Shift right, folding the output bit back through the tap mask.
    always_ff @(posedge clk) begin
        if (rst) state <= SEED;
        else     state <= (state >> 1) ^ (state[0] ? 16'hB400 : 16'h0000);
    end

endmodule

// File: rtl/snake_game_sequencer.sv
// Mode FSM, move tick and collision-free apple placement for the snake.
// Define SNAKE_SPEEDUP_EN to shorten the tick period as the score grows.
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int          TICK_DIV  = 25_000_000,
    parameter int          TICK_STEP = 1_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [5:0]  APPLE_X0  = 6'd10,
    parameter logic [5:0]  APPLE_Y0  = 6'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cubenum,
    input  logic [5:0] node_cube_x,
    input  logic [5:0] node_cube_y,
    output logic [3:0] node,
    output logic [1:0] mode,
    output logic       move_tick,
    output logic [5:0] apple_x,
    output logic [5:0] apple_y,
    output logic       apple_valid
);

    localparam int CW = $clog2(TICK_DIV + 1);

    state_t        state, state_n;
    logic [15:0]   lfsr;
    logic [CW-1:0] cnt, div_q, div_nx;
    logic          start_q, rise, cleared;
    logic          counting, wrap;
    logic [3:0]    cubenum_q;
    logic [5:0]    cx, cy, cand_x, cand_y;
    logic          cand_ok, scan_hit, scan_end;
    logic          dead, eaten;
    logic          unused_lfsr;

    snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign cx          = lfsr[5:0];
    assign cy          = lfsr[13:8];
    assign unused_lfsr = ^{lfsr[15:14], lfsr[7:6]};
    assign cand_ok     = in_field(cx, cy);
    assign rise        = start & ~start_q;
    assign counting    = (state == S_IDLE) || (state == S_RUN);
    assign wrap        = counting && (cnt == div_q - CW'(1));
    assign move_tick   = wrap;
    assign scan_hit    = (node_cube_x == cand_x) && (node_cube_y == cand_y);
    assign scan_end    = ({1'b0, node} == last_node(cubenum));
    assign dead        = (cubenum == 4'd15);
    assign eaten       = (cubenum != cubenum_q);

`ifdef SNAKE_SPEEDUP_EN
    assign div_nx = CW'(tick_div(TICK_DIV, TICK_STEP, cubenum));
`else
    assign div_nx = CW'(tick_div(TICK_DIV, TICK_STEP, 4'd0));
`endif

    // Next-state selection and mode decode.
    always_comb begin
        state_n = state;
        mode    = MODE_IDLE;
        unique case (state)
            S_IDLE: begin
                if (rise && cleared) state_n = S_PLACE;
            end
            S_PLACE: begin
                mode = MODE_PLAY;
                if (cand_ok) state_n = S_SCAN;
            end
            S_SCAN: begin
                mode = MODE_PLAY;
                if (scan_hit)      state_n = S_PLACE;
                else if (scan_end) state_n = S_RUN;
            end
            S_RUN: begin
                mode = MODE_PLAY;
                if (dead)       state_n = S_OVER;
                else if (eaten) state_n = S_PLACE;
            end
            S_OVER: begin
                mode = MODE_OVER;
                if (rise) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Move-tick divider; runs only while idle or playing, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= CW'(TICK_DIV);
        end else if (counting) begin
            if (wrap) begin
                cnt   <= '0;
                div_q <= div_nx;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Apple placement, body scan and game bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            cubenum_q   <= 4'd0;
            cleared     <= 1'b0;
            node        <= 4'd0;
            cand_x      <= 6'd0;
            cand_y      <= 6'd0;
            apple_x     <= APPLE_X0;
            apple_y     <= APPLE_Y0;
            apple_valid <= 1'b0;
        end else begin
            start_q   <= start;
            cubenum_q <= cubenum;
            unique case (state)
                S_IDLE: begin
                    if (wrap) cleared <= 1'b1;
                end
                S_PLACE: begin
                    if (cand_ok) begin
                        cand_x <= cx;
                        cand_y <= cy;
                        node   <= 4'd0;
                    end
                end
                S_SCAN: begin
                    if (!scan_hit) begin
                        if (scan_end) begin
                            apple_x     <= cand_x;
                            apple_y     <= cand_y;
                            apple_valid <= 1'b1;
                            node        <= 4'd0;
                        end else begin
                            node <= node + 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (dead || eaten) apple_valid <= 1'b0;
                end
                S_OVER: begin
                    if (rise) cleared <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Randomized self-checking bench for snake_game_sequencer.
// Body cells come from a behavioural array; apples from an LFSR model.
module tb_snake_game_sequencer;

    localparam int          TD   = 4;
    localparam int          TS   = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cubenum = 4'd0;
    logic [5:0] node_cube_x, node_cube_y;
    logic [3:0] node;
    logic [1:0] mode;
    logic       move_tick;
    logic [5:0] apple_x, apple_y;
    logic       apple_valid;

    int checks = 0;
    int errors = 0;

    logic [5:0]  bx [16];
    logic [5:0]  by [16];
    logic [15:0] m_lfsr;
    int          trace [$];
    logic [5:0]  ex, ey;

    always #5 clk = ~clk;

    snake_game_sequencer #(
        .TICK_DIV  (TD),
        .TICK_STEP (TS),
        .LFSR_SEED (SEED),
        .APPLE_X0  (6'd10),
        .APPLE_Y0  (6'd10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cubenum     (cubenum),
        .node_cube_x (node_cube_x),
        .node_cube_y (node_cube_y),
        .node        (node),
        .mode        (mode),
        .move_tick   (move_tick),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid)
    );

    // Datapath body readback.
    always_comb begin
        node_cube_x = bx[node];
        node_cube_y = by[node];
    end

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit in_rng(input logic [5:0] x, input logic [5:0] y);
        return x >= 1 && x <= 38 && y >= 1 && y <= 28;
    endfunction

    // Random number stream, one step per clock.
    always @(posedge clk) m_lfsr <= rst ? SEED : nxt(m_lfsr);

    // Expected per-cycle placement trace: -1 = drawing, k = scanning node k.
    task automatic predict(input logic [15:0] l0, input int len);
        logic [15:0] l;
        logic [5:0]  cx, cy;
        bit          done;
        l = l0;
        done = 0;
        trace.delete();
        for (int g = 0; g < 4000 && !done; g++) begin
            cx = l[5:0];
            cy = l[13:8];
            trace.push_back(-1);
            l = nxt(l);
            if (in_rng(cx, cy)) begin
                for (int k = 0; k < len; k++) begin
                    trace.push_back(k);
                    l = nxt(l);
                    if (bx[k] == cx && by[k] == cy) break;
                    if (k == len - 1) begin
                        done = 1;
                        ex = cx;
                        ey = cy;
                    end
                end
            end
        end
    endtask

    task automatic rand_body();
        for (int k = 0; k < 16; k++) begin
            bx[k] = 6'($urandom_range(1, 38));
            by[k] = 6'($urandom_range(1, 28));
        end
    endtask

    task automatic run_trace(input string tag);
        foreach (trace[i]) begin
            checks++;
            if (apple_valid !== 1'b0 || mode !== 2'd1 || move_tick !== 1'b0) begin
                errors++;
                $display("FAIL %s cyc%0d valid=%b mode=%0d tick=%b need 0/1/0",
                         tag, i, apple_valid, mode, move_tick);
            end
            if (trace[i] >= 0) begin
                checks++;
                if (node !== 4'(trace[i])) begin
                    errors++;
                    $display("FAIL %s cyc%0d node=%0d need %0d",
                             tag, i, node, trace[i]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (apple_valid !== 1'b1 || apple_x !== ex || apple_y !== ey) begin
            errors++;
            $display("FAIL %s apple valid=%b (%0d,%0d) need 1 (%0d,%0d)",
                     tag, apple_valid, apple_x, apple_y, ex, ey);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (mode !== 2'd0 || apple_valid !== 1'b0 || node !== 4'd0 ||
            move_tick !== 1'b0 || apple_x !== 6'd10 || apple_y !== 6'd10) begin
            errors++;
            $display("FAIL %s mode=%0d valid=%b node=%0d tick=%b apple=(%0d,%0d) need 0 0 0 0 (10,10)",
                     tag, mode, apple_valid, node, move_tick, apple_x, apple_y);
        end
        checks++;
        if (dut.u_lfsr.state !== SEED) begin
            errors++;
            $display("FAIL %s lfsr=%h need %h", tag, dut.u_lfsr.state, SEED);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cubenum = 4'd0;
        for (int k = 0; k < 16; k++) begin
            bx[k] = 6'd0;
            by[k] = 6'd0;
        end
        do_reset();
        check_reset_vals("reset");
        rst = 1'b0;
    endtask

    task automatic test_tick_early_start();
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (move_tick !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL tick cyc%0d tick=%b need %b",
                         i, move_tick, (i % 4 == 3));
            end
            if (i >= 1) begin
                checks++;
                if (mode !== 2'd0) begin
                    errors++;
                    $display("FAIL early_start cyc%0d mode=%0d need 0", i, mode);
                end
            end
            if (i == 1) start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_place();
        rand_body();
        cubenum = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        predict(m_lfsr, 3);
        run_trace("place");
    endtask

    task automatic test_eat();
        rand_body();
        cubenum = 4'd1;
        @(negedge clk);
        predict(m_lfsr, 4);
        run_trace("eat");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (apple_x === bx[k] && apple_y === by[k]) begin
                errors++;
                $display("FAIL eat_body%0d apple=(%0d,%0d) equals body cell",
                         k, apple_x, apple_y);
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] l;
        logic [5:0]  cx, cy;
        cubenum = 4'd2;
        @(negedge clk);
        l = m_lfsr;
        for (int g = 0; g < 1000 && !in_rng(l[5:0], l[13:8]); g++) l = nxt(l);
        cx = l[5:0];
        cy = l[13:8];
        rand_body();
        bx[1] = cx;
        by[1] = cy;
        bx[0] = (cx == 6'd1) ? 6'd2 : 6'd1;
        by[0] = cy;
        predict(m_lfsr, 5);
        run_trace("collide");
        checks++;
        if (apple_x === cx && apple_y === cy) begin
            errors++;
            $display("FAIL collide_cand apple=(%0d,%0d) must differ from (%0d,%0d)",
                     apple_x, apple_y, cx, cy);
        end
    endtask

    task automatic test_over();
        cubenum = 4'd15;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (mode !== 2'd2 || apple_valid !== 1'b0 || move_tick !== 1'b0) begin
            errors++;
            $display("FAIL over_enter mode=%0d valid=%b tick=%b need 2 0 0",
                     mode, apple_valid, move_tick);
        end
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mode !== 2'd2 || move_tick !== 1'b0) begin
                errors++;
                $display("FAIL over_hold cyc%0d mode=%0d tick=%b need 2 0",
                         i, mode, move_tick);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL over_exit mode=%0d need 0", mode);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        cubenum = 4'd5;
        for (int k = 0; k < 16; k++) begin
            bx[k] = 6'd0;
            by[k] = 6'd0;
        end
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (move_tick === 1'b1) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midscan_tick no move_tick within 8 cycles");
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (mode === 2'd1 && node === 4'd2) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midscan_reach node=%0d need 2 within 80 cycles", node);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midscan_rst");
        rst = 1'b0;
    endtask

    task automatic test_period();
        int per;
        bit seen;
`ifdef SNAKE_SPEEDUP_EN
        per = 2;
`else
        per = 4;
`endif
        cubenum = 4'd2;
        do_reset();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (move_tick === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL period_first no move_tick within 8 cycles");
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (move_tick !== (i % per == 0)) begin
                errors++;
                $display("FAIL period cyc%0d tick=%b need %b",
                         i, move_tick, (i % per == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_early_start();
        test_place();
        test_eat();
        test_collision();
        test_over();
        test_reset_mid_scan();
        test_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
